// File: rtl/sync_seq_ctrl.sv
// sync_seq_ctrl: steps a T-trigger datapath through a latched x pattern,
// one clock per step, capturing the datapath y output for each step.
// Optional feature: define SYNC_SEQ_CTRL_ZCNT_EN to add the zero_cnt output
// (count of steps in the current/last run where y_in was 0).
module sync_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] pat_x,
  input  logic [3:0] pat_len,
  input  logic       y_in,
  output logic       seq_t,
  output logic       seq_x,
  output logic       busy,
  output logic       done,
  output logic [7:0] y_cap,
  output logic [3:0] step_cnt
`ifdef SYNC_SEQ_CTRL_ZCNT_EN
  ,
  output logic [3:0] zero_cnt
`endif
);

  localparam int unsigned PAT_W   = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MAX_LEN = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [PAT_W-1:0]   pat_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   len_eff;
  logic [IDX_W-1:0]   step_idx;
  logic               accept;
  logic               step_en;
  logic               last_step;

  // Requested lengths above the pattern width run the full pattern
  always_comb begin
    len_eff = (pat_len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : pat_len;
  end

  // Step index into the pattern; step_cnt never exceeds 7 while in RUN
  assign step_idx  = step_cnt[IDX_W-1:0];
  assign last_step = ((step_cnt + CNT_W'(1)) == len_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs decoded from the registered state
  always_comb begin
    state_d = state_q;
    seq_t   = 1'b0;
    seq_x   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (len_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        seq_t   = 1'b1;
        seq_x   = pat_q[step_idx];
        busy    = 1'b1;
        step_en = 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Run parameters, capture register and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q    <= '0;
      len_q    <= '0;
      y_cap    <= '0;
      step_cnt <= '0;
    end else if (accept) begin
      pat_q    <= pat_x;
      len_q    <= len_eff;
      y_cap    <= '0;
      step_cnt <= '0;
    end else if (step_en) begin
      y_cap[step_idx] <= y_in;
      step_cnt        <= step_cnt + CNT_W'(1);
    end
  end

`ifdef SYNC_SEQ_CTRL_ZCNT_EN
  // Count of RUN steps that captured a zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt <= '0;
    end else if (accept) begin
      zero_cnt <= '0;
    end else if (step_en && !y_in) begin
      zero_cnt <= zero_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sync_seq_ctrl.sv
// tb_sync_seq_ctrl: directed and randomized runs of sync_seq_ctrl checked
// against a per-run reference computed from the step rules.
module tb_sync_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pat_x;
  logic [3:0] pat_len;
  logic       y_in;
  logic       seq_t;
  logic       seq_x;
  logic       busy;
  logic       done;
  logic [7:0] y_cap;
  logic [3:0] step_cnt;
`ifdef SYNC_SEQ_CTRL_ZCNT_EN
  logic [3:0] zero_cnt;
`endif

  int total;
  int bad;

  sync_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pat_x    (pat_x),
    .pat_len  (pat_len),
    .y_in     (y_in),
    .seq_t    (seq_t),
    .seq_x    (seq_x),
    .busy     (busy),
    .done     (done),
    .y_cap    (y_cap),
    .step_cnt (step_cnt)
`ifdef SYNC_SEQ_CTRL_ZCNT_EN
    ,
    .zero_cnt (zero_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All outputs at their reset/idle values with cleared capture state
  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),     0);
    chk({tag, "_done"},  32'(done),     0);
    chk({tag, "_seq_t"}, 32'(seq_t),    0);
    chk({tag, "_seq_x"}, 32'(seq_x),    0);
    chk({tag, "_y_cap"}, 32'(y_cap),    0);
    chk({tag, "_step"},  32'(step_cnt), 0);
  endtask

  // One full run starting at a negedge in IDLE, ending at a negedge in IDLE.
  // mode 0: quiet inputs, 1: random input churn during RUN,
  // mode 2: re-pulse start and clear pat_x during step index 1.
  task automatic do_run(input logic [7:0] px, input logic [3:0] plen,
                        input logic [7:0] ys, input logic keep_start, input int mode);
    int          l;
    int          zeros;
    logic [7:0]  exp_cap;
    l       = (plen > 4'd8) ? 8 : int'(plen);
    exp_cap = 8'h00;
    zeros   = 0;
    for (int k = 0; k < l; k++) begin
      exp_cap[k] = ys[k];
      if (!ys[k]) zeros++;
    end

    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    pat_x   = px;
    pat_len = plen;
    start   = 1'b1;
    y_in    = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;

    for (int k = 0; k < l; k++) begin
      chk("run_busy",  32'(busy),     1);
      chk("run_seq_t", 32'(seq_t),    1);
      chk("run_seq_x", 32'(seq_x),    32'(px[k]));
      chk("run_step",  32'(step_cnt), 32'(k));
      chk("run_done",  32'(done),     0);
      y_in = ys[k];
      if (mode == 1) begin
        pat_x   = 8'($urandom);
        pat_len = 4'($urandom);
        start   = 1'($urandom);
      end else if (mode == 2 && k == 1) begin
        pat_x = 8'h00;
        start = 1'b1;
      end else if (mode == 2 && k == 2) begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end

    chk("dn_done",  32'(done),     1);
    chk("dn_busy",  32'(busy),     0);
    chk("dn_seq_t", 32'(seq_t),    0);
    chk("dn_seq_x", 32'(seq_x),    0);
    chk("dn_y_cap", 32'(y_cap),    32'(exp_cap));
    chk("dn_step",  32'(step_cnt), 32'(l));
`ifdef SYNC_SEQ_CTRL_ZCNT_EN
    chk("dn_zcnt",  32'(zero_cnt), 32'(zeros));
`endif
    start   = keep_start;
    pat_x   = 8'($urandom);
    pat_len = 4'($urandom);
    y_in    = 1'($urandom);
    @(posedge clk);
    @(negedge clk);

    chk("post_done",  32'(done),     0);
    chk("post_busy",  32'(busy),     0);
    chk("post_seq_t", 32'(seq_t),    0);
    chk("post_y_cap", 32'(y_cap),    32'(exp_cap));
    chk("post_step",  32'(step_cnt), 32'(l));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    pat_x   = 8'h00;
    pat_len = 4'd0;
    y_in    = 1'b0;

    // Reset state
    #1;
    chk_all_zero("reset");
`ifdef SYNC_SEQ_CTRL_ZCNT_EN
    chk("reset_zcnt", 32'(zero_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // Basic run: x pattern 101, y 1,0,1
    do_run(8'b0000_0101, 4'd3, 8'b0000_0101, 1'b0, 0);
    // Zero length goes straight to DONE
    do_run(8'hA5, 4'd0, 8'h00, 1'b0, 0);
    // Length clamp
    do_run(8'hFF, 4'd12, 8'hFF, 1'b0, 0);
    // Start and pattern changes during RUN are ignored
    do_run(8'h0F, 4'd4, 8'h0B, 1'b0, 2);
    // Zero counting pattern y = 0,1,0,0
    do_run(8'h3C, 4'd4, 8'b0000_0010, 1'b0, 0);
    // Maximum literal length and 15 clamp
    do_run(8'h5A, 4'd8, 8'hC3, 1'b0, 1);
    do_run(8'h96, 4'd15, 8'h3E, 1'b0, 1);

    // Reset between edges in step 3 of a 6-step run
    pat_x   = 8'h3F;
    pat_len = 4'd6;
    y_in    = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_step", 32'(step_cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_done", 32'(done), 0);
      chk("abort_busy", 32'(busy), 0);
    end
    do_run(8'h02, 4'd2, 8'h01, 1'b0, 0);

    // Held start: back-to-back runs with start kept high through DONE
    do_run(8'h81, 4'd2, 8'h03, 1'b1, 0);
    do_run(8'h7E, 4'd1, 8'h00, 1'b1, 0);
    do_run(8'h44, 4'd3, 8'h06, 1'b0, 0);

    // Randomized runs
    for (int r = 0; r < 24; r++) begin
      do_run(8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom), int'($urandom_range(0, 1)));
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_seq_ctrl.md
SYNC_SEQ_CTRL -- requirements
Module: sync_seq_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  run request, sampled only in IDLE.
- pat_x  in  8  x pattern; bit k drives step k.
- pat_len  in  4  number of steps; 0..8, values 9..15 clamp to 8.
- y_in  in  1  y output of the T-trigger sequential datapath, combinational in the current cycle.
- seq_t  out  1  t drive to the datapath.
- seq_x  out  1  x drive to the datapath.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- y_cap  out  8  captured y; bit k holds step k.
- step_cnt  out  4  steps completed in the current or last run.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE, registered on the rising edge of clk.
REQ-004 In IDLE with start=1 and effective length L>0, the block SHALL:
- latch pat_x and L;
- clear y_cap and step_cnt;
- enter RUN on the next edge.
REQ-005 In IDLE with start=1 and L=0, the block SHALL clear y_cap and step_cnt and enter DONE directly, with no RUN cycles.
REQ-006 In RUN, outputs SHALL be combinational from registered state: seq_t=1, seq_x=latched_pat[step_cnt], busy=1.
REQ-007 On each RUN edge, the block SHALL write y_in into y_cap[step_cnt] and increment step_cnt. The datapath SHALL see exactly one clock per step.
REQ-008 RUN SHALL exit to DONE on the edge where step_cnt+1 equals L. RUN SHALL therefore last exactly L cycles.
REQ-009 DONE SHALL last exactly one cycle, with done=1, busy=0, seq_t=0 and seq_x=0. It SHALL then return to IDLE unconditionally.
REQ-010 In IDLE and DONE, seq_t and seq_x SHALL be 0, so the datapath q0 holds.
REQ-011 Start handling:
- start in RUN or DONE SHALL be ignored and not queued;
- a start held high in IDLE SHALL begin a new run each time IDLE is re-entered.
REQ-012 Changes to pat_x and pat_len during RUN SHALL NOT affect the run in progress.
REQ-013 y_cap and step_cnt SHALL hold their values after DONE until the next accepted start.
REQ-014 Latency: start accepted at edge N gives done=1 in the cycle after edge N+L. For L=0, done=1 in the cycle after edge N.

Reset
REQ-015 rst=1 SHALL immediately force, without waiting for a clock edge:
- state=IDLE;
- seq_t=0, seq_x=0, busy=0, done=0;
- y_cap=8'h00, step_cnt=0;
- latched pattern and length to 0.
REQ-016 Reset asserted mid-RUN SHALL abort the run with no done pulse. The first start after reset deassertion SHALL behave as from power-up.

Configuration
REQ-017 Macro SYNC_SEQ_CTRL_ZCNT_EN, when defined, SHALL add an output zero_cnt (4 bits) with this behaviour:
- cleared on accepted start and on reset;
- incremented on each RUN edge where y_in=0;
- held after DONE.
REQ-018 Without SYNC_SEQ_CTRL_ZCNT_EN, the zero_cnt port and its logic SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-019 Basic run: pat_x=8'b0000_0101, pat_len=3, start pulsed, y_in driven 1,0,1 in RUN cycles → seq_x=1,0,1 with seq_t=1 for 3 cycles; done pulse 4th cycle after start edge; y_cap=8'h05; step_cnt=3.
REQ-020 Zero length: pat_len=0, start → no busy cycle; done=1 the cycle after start edge; y_cap=8'h00; step_cnt=0.
REQ-021 Clamp: pat_len=12, pat_x=8'hFF, y_in=1 constant → busy exactly 8 cycles; y_cap=8'hFF; step_cnt=8.
REQ-022 Busy immunity: start re-pulsed and pat_x changed to 8'h00 during step 2 of a pat_len=4, pat_x=8'h0F run → seq_x stays 1 all 4 steps; exactly one done pulse.
REQ-023 Reset mid-run: rst asserted between edges in step 3 of 6 → all outputs 0 immediately; no done; a subsequent pat_len=2 run completes normally.
REQ-024 With SYNC_SEQ_CTRL_ZCNT_EN: y_in=0,1,0,0 over pat_len=4 → zero_cnt=3 at done.
